multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the yIF/yID/yEX/yDM/yWB RISC-V datapath; it is the block that drives the datapath control inputs.
- It takes the fetched instruction and the ALU zero flag.
- It steps each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- It drives RegWrite, ALUSrc, op, Mem2Reg, MemRead, MemWrite and the PC update controls.
- It halts after a programmed instruction count or on an illegal opcode.

Parameters:
MAX_INSNS, 43, number of retired instructions after which the FSM enters HALT (0 = no limit)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level; leaving IDLE requires start=1
ins  input  32  instruction word from yIF
zero  input  1  ALU zero flag from yEX
RegWrite  output  1  register-file write enable
ALUSrc  output  1  1 = immediate operand, 0 = rd2
op  output  3  ALU op: 010 add, 110 sub
Mem2Reg  output  1  1 = writeback from memory
MemRead  output  1  data-memory read enable
MemWrite  output  1  data-memory write enable
ir_we  output  1  latch ins into internal opcode register
pc_we  output  1  PC register update strobe
pc_sel  output  2  0 = PCp4, 1 = PC+(imm<<1), 2 = PC+(jTarget<<2)
retired  output  CNT_W  count of completed instructions
halted  output  1  FSM in HALT
illegal  output  1  sticky; set on unknown opcode

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All control outputs 0, op=010, pc_sel=0, retired=0, halted=0, illegal=0. Reset applies immediately mid-instruction; no partial writes are issued after reset.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. One state per clock.
- IDLE -> FETCH when start=1.
- FETCH: ir_we=1; the opcode register captures ins[6:0] at the clock edge. FETCH -> DECODE.
- DECODE: no enables asserted.
  - 0x33 (R), 0x13 (I-ALU), 0x03 (load), 0x23 (store), 0x63 (beq): -> EXEC.
  - 0x6F (jal): -> EXEC.
  - Any other opcode: illegal=1, -> HALT, no PC update.
- Outputs are Moore, decoded from state and the latched opcode.
- EXEC:
  - ALUSrc=1 for 0x13, 0x03, 0x23, 0x6F; ALUSrc=0 for 0x33, 0x63.
  - op=110 for 0x63; op=010 otherwise.
  - 0x63 is its last state: pc_we=1, pc_sel=1 if zero=1, else 0 (zero is sampled in EXEC).
  - Next state: 0x03/0x23 -> MEM; 0x33/0x13/0x6F -> WB.
- MEM:
  - 0x03: MemRead=1, next WB.
  - 0x23: MemWrite=1; last state (pc_we=1, pc_sel=0).
  - ALUSrc/op are held from EXEC.
- WB: RegWrite=1, ALUSrc/op held, Mem2Reg=1 only for 0x03, pc_we=1.
  - pc_sel=2 for 0x6F; pc_sel=0 otherwise.
- Latency: branch 3 cycles; R/I/store/jal 4; load 5.
- RegWrite, MemRead, MemWrite and pc_we are each high for exactly one cycle per instruction and are never high together with ir_we.
- Retire, in the last state of each instruction:
  - On the pc_we cycle, retired increments (wraps at 2^CNT_W).
  - If MAX_INSNS != 0 and retired+1 == MAX_INSNS, next state is HALT; otherwise FETCH.
- HALT: absorbing until reset. halted=1; all enables 0; start is ignored.
- illegal is cleared only by reset.
- start is sampled only in IDLE; deasserting start mid-instruction has no effect.

Test Plan:
- Reset/idle: rst_n=0 then 1, start=0 for 5 cycles -> state IDLE; all enables 0; retired=0. Asserting rst_n=0 mid-WB -> RegWrite drops to 0 combinationally after reset propagates.
- R-type: start=1, ins=0x002081B3 -> FETCH, DECODE, EXEC(ALUSrc=0, op=010), WB(RegWrite=1, Mem2Reg=0, pc_we=1, pc_sel=0); retired=1 after 4 cycles.
- Load/store: ins=0x00002283 -> MEM cycle with MemRead=1, then WB with Mem2Reg=1, RegWrite=1 (5 cycles). Then ins=0x00502023 -> MEM with MemWrite=1, pc_we=1, RegWrite never 1 (4 cycles).
- Branch: ins=0x00000463 with zero=1 in EXEC -> op=110, pc_we=1, pc_sel=1 in cycle 3. Repeat with zero=0 -> pc_sel=0. RegWrite and MemWrite stay 0 throughout.
- JAL and illegal: ins=0x008000EF -> WB with RegWrite=1, pc_sel=2. Then ins=0x0000007F -> illegal=1, halted=1 on the cycle after DECODE; pc_we never asserted; retired unchanged.
- Count limit: MAX_INSNS=3, stream of three 0x00100093 (addi) -> retired=3, halted=1 after 12 cycles; further start pulses produce no FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the yIF/yID/yEX/yDM/yWB datapath.
// Steps each instruction through FETCH..WB and drives the datapath enables.
module multicycle_ctrl #(
  parameter int unsigned MAX_INSNS = 43,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      ins,
  input  logic             zero,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             Mem2Reg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_HALT
  } state_e;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INSNS);
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  state_e           state_q, state_d;
  logic [6:0]       opc_q, opc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;

  logic             is_ld, is_st, is_br, is_jal;
  logic             is_imm, legal, last;
  logic [CNT_W-1:0] cnt_inc;
  logic             ins_unused;

  assign ins_unused = ^ins[31:7];

  assign is_ld  = (opc_q == OP_LD);
  assign is_st  = (opc_q == OP_ST);
  assign is_br  = (opc_q == OP_BR);
  assign is_jal = (opc_q == OP_JAL);
  assign is_imm = (opc_q == OP_I) || is_ld
               || is_st || is_jal;
  assign legal  = (opc_q == OP_R) || is_imm
               || is_br;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    cnt_d    = cnt_q;
    ill_d    = ill_q;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    op       = ALU_ADD;
    Mem2Reg  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    last     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_we   = 1'b1;
        opc_d   = ins[6:0];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          ill_d   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        ALUSrc = is_imm;
        op     = is_br ? ALU_SUB : ALU_ADD;
        if (is_br) begin
          pc_we  = 1'b1;
          pc_sel = zero ? 2'd1 : 2'd0;
          last   = 1'b1;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ALUSrc = is_imm;
        op     = ALU_ADD;
        if (is_ld) begin
          MemRead = 1'b1;
          state_d = S_WB;
        end else begin
          MemWrite = 1'b1;
          pc_we    = 1'b1;
          last     = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        ALUSrc   = is_imm;
        op       = ALU_ADD;
        Mem2Reg  = is_ld;
        pc_we    = 1'b1;
        pc_sel   = is_jal ? 2'd2 : 2'd0;
        last     = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Retire on the instruction's pc_we cycle
    if (last) begin
      cnt_d = cnt_inc;
      if ((MAX_INSNS != 0) && (cnt_inc == MAX_C))
        state_d = S_HALT;
      else
        state_d = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opc_q   <= 7'h00;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  assign retired = cnt_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = ill_q;

endmodule
